// File: rtl/charge_session_timer.sv
// Coin-credited charging session timer: converts accepted coins into seconds of charge,
// drives the relay enable and counts the credit down on a prescaled one-second tick.
module charge_session_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int SEC_PER_PESO  = 60,
  parameter int TIME_W        = 16,
  parameter int MAX_TIME      = 3600
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [3:0]        Mode,
  input  logic              Coin_Strobe,
  input  logic              Start,
  input  logic              Stop,
  output logic              Charging,
  output logic [TIME_W-1:0] Time_Left,
  output logic              Busy,
  output logic              Done,
  output logic              Sat
);

  localparam int PRE_W = $clog2(TICKS_PER_SEC);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  // Two guard bits: one for carry past TIME_W, one for the sign of the -1 term.
  localparam int SUM_W = TIME_W + 2;
  typedef logic signed [SUM_W-1:0] sum_t;
  localparam sum_t ADD1  = sum_t'(SEC_PER_PESO);
  localparam sum_t ADD5  = sum_t'(5 * SEC_PER_PESO);
  localparam sum_t MAX_S = sum_t'(MAX_TIME);

  typedef enum logic [1:0] {IDLE, CREDITED, CHARGING, DONE} state_t;

  state_t            state, state_n;
  logic [PRE_W-1:0]  pre, pre_n;
  logic [TIME_W-1:0] time_n;
  logic              sat_n;
  logic              coin_ok;
  logic              tick;
  sum_t              add, dec, sum;
  logic              sat_c;
  logic [TIME_W-1:0] clipped;

  // Returns {clipped_flag, value} with the value held at the ceiling.
  function automatic logic [TIME_W:0] clip_time(input sum_t s);
    if (s > MAX_S) clip_time = {1'b1, TIME_W'(MAX_TIME)};
    else           clip_time = {1'b0, s[TIME_W-1:0]};
  endfunction

  always_comb begin
    coin_ok = Coin_Strobe && (Mode == 4'd1 || Mode == 4'd5);
    add     = !coin_ok ? sum_t'(0) : ((Mode == 4'd5) ? ADD5 : ADD1);
    tick    = (state == CHARGING) && (pre == PRE_MAX);
    dec     = tick ? sum_t'(1) : sum_t'(0);
    sum     = $signed({2'b00, Time_Left}) - dec + add;
    {sat_c, clipped} = clip_time(sum);

    state_n = state;
    pre_n   = '0;
    time_n  = Time_Left;
    sat_n   = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (coin_ok) begin
          state_n = CREDITED;
          time_n  = clipped;
          sat_n   = sat_c;
        end
      end
      CREDITED: begin
        if (Stop) begin
          state_n = IDLE;
          time_n  = '0;
        end else begin
          if (coin_ok) begin
            time_n = clipped;
            sat_n  = sat_c;
          end
          if (Start) state_n = CHARGING;
        end
      end
      CHARGING: begin
        if (Stop) begin
          state_n = IDLE;
          time_n  = '0;
        end else begin
          pre_n = tick ? '0 : pre + 1'b1;
          // Expiry only when the last second ticks away with no fresh credit.
          if (tick && Time_Left == TIME_W'(1) && !coin_ok) begin
            state_n = DONE;
            time_n  = '0;
          end else if (tick || coin_ok) begin
            time_n = clipped;
            sat_n  = sat_c;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      pre       <= '0;
      Time_Left <= '0;
      Charging  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Sat       <= 1'b0;
    end else begin
      state     <= state_n;
      pre       <= pre_n;
      Time_Left <= time_n;
      Charging  <= (state_n == CHARGING);
      Busy      <= (state_n == CREDITED) || (state_n == CHARGING);
      Done      <= (state_n == DONE);
      Sat       <= sat_n;
    end
  end

endmodule

// File: tb/tb_charge_session_timer.sv
// Scoreboard bench for charge_session_timer: a cycle-level session model predicts the
// outputs after every edge; a monitor pops and compares them independently of the driver.
module tb_charge_session_timer;

  localparam int TPS    = 4;
  localparam int SPP    = 2;
  localparam int TW     = 16;
  localparam int MAXT   = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    mode = 4'd0;
  logic          strobe = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          charging;
  logic [TW-1:0] time_left;
  logic          busy;
  logic          done;
  logic          sat;

  charge_session_timer #(
    .TICKS_PER_SEC(TPS),
    .SEC_PER_PESO (SPP),
    .TIME_W       (TW),
    .MAX_TIME     (MAXT)
  ) dut (
    .Clock      (clk),
    .Reset      (reset),
    .Mode       (mode),
    .Coin_Strobe(strobe),
    .Start      (start),
    .Stop       (stop),
    .Charging   (charging),
    .Time_Left  (time_left),
    .Busy       (busy),
    .Done       (done),
    .Sat        (sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          charging;
    logic [TW-1:0] time_left;
    logic          busy;
    logic          done;
    logic          sat;
  } obs_t;

  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Session model: remaining seconds, whether the relay is on, cycles into the current second.
  int m_time = 0;
  bit m_on   = 0;
  int m_cnt  = 0;

  task automatic drive(input bit r, input logic [3:0] md, input bit stb,
                       input bit st, input bit sp);
    obs_t e;
    int   add;
    int   t;
    bit   e_done;
    bit   e_sat;
    @(negedge clk);
    reset  = r;
    mode   = md;
    strobe = stb;
    start  = st;
    stop   = sp;
    add    = (stb && (md == 4'd1 || md == 4'd5)) ? int'(md) * SPP : 0;
    e_done = 0;
    e_sat  = 0;
    if (r) begin
      m_time = 0; m_on = 0; m_cnt = 0;
    end else if (m_on) begin
      if (sp) begin
        m_on = 0; m_time = 0;
      end else begin
        m_cnt++;
        t = m_time + add;
        if (m_cnt == TPS) begin
          m_cnt = 0;
          t = t - 1;
        end
        if (t == 0) begin
          m_on = 0; m_time = 0; e_done = 1;
        end else begin
          e_sat  = (t > MAXT);
          m_time = (t > MAXT) ? MAXT : t;
        end
      end
    end else if (m_time > 0) begin
      if (sp) m_time = 0;
      else begin
        if (add > 0) begin
          t = m_time + add;
          e_sat  = (t > MAXT);
          m_time = (t > MAXT) ? MAXT : t;
        end
        if (st) begin
          m_on = 1; m_cnt = 0;
        end
      end
    end else if (add > 0) begin
      e_sat  = (add > MAXT);
      m_time = (add > MAXT) ? MAXT : add;
    end
    e.charging  = m_on;
    e.time_left = TW'(m_time);
    e.busy      = m_on || (m_time > 0);
    e.done      = e_done;
    e.sat       = e_sat;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'd0, 0, 0, 0);
  endtask

  task automatic coin(input logic [3:0] md);
    drive(0, md, 1, 0, 0);
  endtask

  // Monitor: the DUT presents a fresh output vector after every edge.
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{charging, time_left, busy, done, sat};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs vec=%0d got chg=%0b t=%0d busy=%0b done=%0b sat=%0b exp chg=%0b t=%0d busy=%0b done=%0b sat=%0b",
                 vectors, a.charging, a.time_left, a.busy, a.done, a.sat,
                 e.charging, e.time_left, e.busy, e.done, e.sat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    drive(1, 4'd0, 0, 0, 0);
    drive(1, 4'd0, 0, 0, 0);
    idle(1);

    // Full session: 10 s credit runs down to a single Done pulse.
    coin(4'd5);
    drive(0, 4'd0, 0, 1, 0);
    idle(46);

    // Only Mode 1 and 5 add credit.
    coin(4'd1);
    coin(4'd3);
    coin(4'd0);
    idle(2);
    drive(0, 4'd0, 0, 0, 1);

    // Saturation at the ceiling.
    coin(4'd5);
    coin(4'd5);
    coin(4'd5);
    idle(1);
    drive(0, 4'd0, 0, 0, 1);

    // Coin on the final tick keeps the session alive.
    coin(4'd1);
    drive(0, 4'd0, 0, 1, 0);
    guard = 0;
    while (!(m_on && m_time == 1 && m_cnt == TPS - 1) && guard < 50) begin
      idle(1);
      guard++;
    end
    coin(4'd1);
    idle(12);

    // Stop with coin mid-charge, then Reset with coin mid-charge.
    coin(4'd5);
    drive(0, 4'd0, 0, 1, 0);
    idle(6);
    drive(0, 4'd5, 1, 0, 1);
    idle(2);
    coin(4'd5);
    drive(0, 4'd0, 0, 1, 0);
    idle(6);
    drive(1, 4'd5, 1, 0, 0);
    idle(2);

    // Start and Stop together in CREDITED.
    coin(4'd1);
    drive(0, 4'd0, 0, 1, 1);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] md;
      int sel;
      sel = $urandom_range(0, 4);
      md  = (sel == 0) ? 4'd1 : (sel == 1) ? 4'd5 : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 199) == 0), md, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0));
    end
    idle(2);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
